// File: rtl/bram_burst_reader.sv
// Burst read controller for a 1-cycle-latency BRAM port with a 2-entry valid/ready output buffer.
// Optional same-cycle write forwarding is enabled by defining BRAM_READ_BYPASS_EN.
module bram_burst_reader #(
  parameter int SIZE       = 512,
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 10
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic                  enb,
  output logic [ADDR_WIDTH-1:0] addrb,
  input  logic [DATA_WIDTH-1:0] dob,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_last,
  output logic                  busy,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  // Reset asserts asynchronously but is released in step with clk.
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_n_int;

  assign rst_sync_d = {rst_sync_q[0], 1'b1};
  assign rst_n_int  = rst_sync_q[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= '0;
    else          rst_sync_q <= rst_sync_d;
  end

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, addr_next;
  logic [LEN_WIDTH-1:0]  remain_q, remain_d;
  logic                  inflight_q, inflight_d;
  logic                  inflight_last_q, inflight_last_d;
  logic [DATA_WIDTH-1:0] fifo_dat_q [2];
  logic [DATA_WIDTH-1:0] fifo_dat_d [2];
  logic [1:0]            fifo_last_q, fifo_last_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            count_q, count_d;

  logic                  pop, push, issue;
  logic [2:0]            occ;
  logic [DATA_WIDTH-1:0] push_data;

  assign rsp_valid = (count_q != 2'd0);
  assign rsp_data  = fifo_dat_q[rd_ptr_q];
  assign rsp_last  = fifo_last_q[rd_ptr_q];
  assign pop       = rsp_valid && rsp_ready;
  assign push      = inflight_q;

  // Occupancy counts the word already in the BRAM pipe so the buffer can never overflow.
  assign occ       = 3'(count_q) + 3'(inflight_q) - 3'(pop);
  assign issue     = (state_q == READ) && (occ < 3'd2);

  assign enb       = issue;
  assign addrb     = addr_q;
  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign addr_next = (addr_q == ADDR_WIDTH'(SIZE - 1)) ? '0 : addr_q + ADDR_WIDTH'(1);

`ifdef BRAM_READ_BYPASS_EN
  logic                  byp_vld_q, byp_vld_d;
  logic [DATA_WIDTH-1:0] byp_dat_q, byp_dat_d;

  always_comb begin
    byp_vld_d = issue && wr_en && (wr_addr == addr_q);
    byp_dat_d = byp_vld_d ? wr_data : byp_dat_q;
  end

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      byp_vld_q <= 1'b0;
      byp_dat_q <= '0;
    end else begin
      byp_vld_q <= byp_vld_d;
      byp_dat_q <= byp_dat_d;
    end
  end

  assign push_data = byp_vld_q ? byp_dat_q : dob;
`else
  logic unused_wr;
  assign unused_wr = ^{wr_en, wr_addr, wr_data};
  assign push_data = dob;
`endif

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d   = cmd_addr;
          remain_d = cmd_len;
          state_d  = READ;
        end
      end
      READ: begin
        if (issue) begin
          addr_d = addr_next;
          if (remain_q == '0) state_d = DRAIN;
          else                remain_d = remain_q - LEN_WIDTH'(1);
        end
      end
      DRAIN: begin
        if (pop && rsp_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    inflight_d      = issue;
    inflight_last_d = issue && (remain_q == '0);
    fifo_dat_d      = fifo_dat_q;
    fifo_last_d     = fifo_last_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    if (push) begin
      fifo_dat_d[wr_ptr_q]  = push_data;
      fifo_last_d[wr_ptr_q] = inflight_last_q;
      wr_ptr_d              = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    count_d = count_q + 2'(push) - 2'(pop);
  end

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      remain_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      fifo_dat_q[0]   <= '0;
      fifo_dat_q[1]   <= '0;
      fifo_last_q     <= '0;
      wr_ptr_q        <= 1'b0;
      rd_ptr_q        <= 1'b0;
      count_q         <= '0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      remain_q        <= remain_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      fifo_dat_q      <= fifo_dat_d;
      fifo_last_q     <= fifo_last_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
    end
  end

endmodule

// File: tb/tb_bram_burst_reader.sv
// Scoreboard bench for bram_burst_reader: a BRAM model feeds the DUT; expected words and addresses queued per command.
module tb_bram_burst_reader;
  localparam int SIZE = 512;
  localparam int AW   = 9;
  localparam int DW   = 32;
  localparam int LW   = 10;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic          enb;
  logic [AW-1:0] addrb;
  logic [DW-1:0] dob;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_last;
  logic          busy;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bram_burst_reader #(.SIZE(SIZE), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .enb(enb), .addrb(addrb), .dob(dob),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .busy(busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  // BRAM model: registered read, one-cycle latency
  logic [DW-1:0] mem [SIZE];
  logic          preload;
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < SIZE; i++) mem[i] <= DW'(32'h1000 + i);
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (enb) dob <= mem[addrb];
  end

  // rsp_ready: manual, random, or toggling
  int   ready_mode;
  logic man_ready;
  logic auto_ready = 1'b1;
  assign rsp_ready = (ready_mode == 0) ? man_ready : auto_ready;
  always @(posedge clk) begin
    #1;
    if (ready_mode == 1)      auto_ready = 1'($urandom_range(0, 1));
    else if (ready_mode == 2) auto_ready = ~auto_ready;
  end

  logic [DW:0]   exp_q[$];
  logic [AW-1:0] addr_exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor
  int          enb_cnt = 0;
  int          last_cnt = 0;
  int          valid_cnt = 0;
  logic        prev_stall = 1'b0;
  logic [DW:0] prev_word;
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (rsp_valid) valid_cnt++;
      if (enb) begin
        enb_cnt++;
        if (addr_exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_enb: got addrb %0h expected no read", addrb);
        end else begin
          check("addrb", 64'(addrb), 64'(addr_exp_q.pop_front()));
        end
      end
      if (prev_stall)
        check("stall_hold", 64'({rsp_valid, rsp_last, rsp_data}), 64'({1'b1, prev_word}));
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rsp: got %0h expected no response", rsp_data);
        end else begin
          if (rsp_last) last_cnt++;
          check("rsp_word", 64'({rsp_last, rsp_data}), 64'(exp_q.pop_front()));
        end
      end
      prev_stall = rsp_valid && !rsp_ready;
      prev_word  = {rsp_last, rsp_data};
    end
  end

  task automatic send_cmd(input int a, input int l, input bit push_data);
    int n = 0;
    @(posedge clk); #1;
    while (!cmd_ready && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    check("cmd_ready_wait", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1;
    cmd_addr  = AW'(a);
    cmd_len   = LW'(l);
    for (int i = 0; i <= l; i++) begin
      addr_exp_q.push_back(AW'((a + i) % SIZE));
      if (push_data) exp_q.push_back({(i == l), mem[(a + i) % SIZE]});
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(posedge clk); #1;
    while ((busy || exp_q.size() != 0) && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    check("drained", 64'(exp_q.size()), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);
  endtask

  task automatic check_reset_outputs();
    check("rst_enb", 64'(enb), 64'd0);
    check("rst_addrb", 64'(addrb), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_data", 64'(rsp_data), 64'd0);
    check("rst_rsp_last", 64'(rsp_last), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    reset_n = 1'b0; preload = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; ready_mode = 0; man_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 preload = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (3) @(posedge clk);

    // Basic burst with exact cycle timing
    send_cmd(4, 3, 1'b1);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      check("t1_enb", 64'(enb), 64'(k <= 4));
      check("t1_valid", 64'(rsp_valid), 64'(k >= 3 && k <= 6));
      check("t1_last", 64'(rsp_last), 64'(k == 6));
      check("t1_cmd_ready", 64'(cmd_ready), 64'(k >= 7));
    end
    wait_idle();

    // Address wrap
    send_cmd(510, 3, 1'b1);
    wait_idle();

    // Backpressure: ready low through cycle 9
    man_ready = 1'b0;
    base = enb_cnt;
    send_cmd(0, 7, 1'b1);
    for (int k = 1; k <= 9; k++) @(negedge clk);
    check("bp_enb_pulses", 64'(enb_cnt - base), 64'd2);
    check("bp_enb_low", 64'(enb), 64'd0);
    check("bp_valid", 64'(rsp_valid), 64'd1);
    check("bp_head", 64'(rsp_data), 64'h1000);
    @(posedge clk); #1 man_ready = 1'b1;
    wait_idle();

    // Toggling ready
    ready_mode = 2;
    base = last_cnt;
    send_cmd(100, 7, 1'b1);
    wait_idle();
    check("toggle_last_once", 64'(last_cnt - base), 64'd1);

    // Random bursts with random backpressure
    ready_mode = 1;
    for (int n = 0; n < 25; n++) begin
      send_cmd(int'($urandom % SIZE), int'($urandom_range(0, 20)), 1'b1);
      if ($urandom_range(0, 3) == 0) wait_idle();
    end
    wait_idle();
    send_cmd(300, 1023, 1'b1);
    wait_idle();

    // Reset mid-burst
    ready_mode = 0; man_ready = 1'b1;
    send_cmd(0, 15, 1'b1);
    repeat (5) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check_reset_outputs();
    exp_q.delete();
    addr_exp_q.delete();
    @(posedge clk); #1 reset_n = 1'b1;
    base = valid_cnt;
    repeat (12) @(negedge clk);
    check("post_reset_quiet", 64'(valid_cnt - base), 64'd0);
    send_cmd(2, 0, 1'b1);
    wait_idle();

`ifdef BRAM_READ_BYPASS_EN
    // Same-cycle write forwarding at address 5
    send_cmd(5, 0, 1'b0);
    exp_q.push_back({1'b1, 32'hDEADBEEF});
    wr_en = 1'b1; wr_addr = AW'(5); wr_data = 32'hDEADBEEF;
    @(posedge clk); #1 wr_en = 1'b0;
    wait_idle();
`endif

    check("addr_queue_empty", 64'(addr_exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bram_burst_reader.md
Name: bram_burst_reader

Overview:
- Read-side controller for the simple-dual-port BRAM used as register file and scratch memory.
- Accepts one burst command (start address, word count) and drives the BRAM read port (enb/addrb), covering its 1-cycle registered read latency.
- Returns words in order on a valid/ready stream. A 2-entry output buffer absorbs backpressure without losing words.
- Optional write-port monitor forwards same-cycle write data, because the BRAM gives no guarantee on read/write address collisions.

Parameters:
- SIZE, 512, number of BRAM words; the address wraps at SIZE-1.
- ADDR_WIDTH, 9, BRAM address width.
- DATA_WIDTH, 32, BRAM word width.
- LEN_WIDTH, 10, width of the burst length field.

Ports:
- clk  in  1  single clock for all logic and for the BRAM read port
- reset_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  burst command valid
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_addr  in  ADDR_WIDTH  start address
- cmd_len  in  LEN_WIDTH  word count minus 1 (0 = 1 word, max 2^LEN_WIDTH words)
- enb  out  1  BRAM read enable
- addrb  out  ADDR_WIDTH  BRAM read address
- dob  in  DATA_WIDTH  BRAM read data, valid the cycle after enb
- rsp_valid  out  1  response word valid
- rsp_ready  in  1  consumer ready
- rsp_data  out  DATA_WIDTH  response word
- rsp_last  out  1  marks the final word of the burst
- busy  out  1  high whenever the state is not IDLE
- wr_en  in  1  monitor of the BRAM write port (wea && ena)
- wr_addr  in  ADDR_WIDTH  monitored write address
- wr_data  in  DATA_WIDTH  monitored write data

Behaviour:
- Reset (async assert, sync deassert internally): state=IDLE, enb=0, addrb=0, rsp_valid=0, rsp_data=0, rsp_last=0, busy=0, cmd_ready=1, FIFO empty, in-flight flag cleared.
- States and transitions:
  - IDLE -> READ on command handshake. cmd_addr and cmd_len are latched into the address register and the remaining-issue counter.
  - READ -> DRAIN after the last read is issued.
  - DRAIN -> IDLE on the cycle the rsp_last word is popped.
- cmd_ready = 1 only in IDLE. A new command can be accepted the cycle after the last word pops.
- Issue rule: enb=1 in cycle t when in READ and (fifo_count + inflight - pop_t) < 2, where pop_t = rsp_valid && rsp_ready in cycle t.
  - addrb = current address.
  - Address increments modulo SIZE: SIZE-1 -> 0.
  - Remaining-issue counter decrements per issue.
- Capture: the inflight flag is set for cycle t+1. dob is written into the FIFO at the end of t+1, together with a last bit (set when this was the final issue).
- FIFO: 2 entries. rsp_valid = FIFO non-empty. rsp_data and rsp_last come from the head entry.
  - Push and pop in the same cycle is legal.
  - Data must not change while rsp_valid && !rsp_ready.
- Latency: command accepted in cycle 0 -> first enb in cycle 1 -> rsp_valid in cycle 3.
- Throughput: with rsp_ready held high, one word per cycle.
- Backpressure: with rsp_ready low, at most 2 words are buffered. Further issue stalls, enb=0 and addrb holds.
- Single-word burst (cmd_len=0): READ issues once and goes straight to DRAIN. That word has rsp_last=1.
- Max burst (cmd_len=2^LEN_WIDTH-1): the counter does not overflow, and addresses wrap as many times as needed.
- Reset mid-burst: the burst is aborted and buffered or in-flight data is discarded. No response is emitted after reset_n rises until a new command arrives.
- Snapshot semantics: words already in the FIFO are never updated by later writes.

Optional Feature:
- Macro: BRAM_READ_BYPASS_EN.
- Defined: if wr_en=1 and wr_addr==addrb in an issue cycle, wr_data is registered with a bypass flag. In the capture cycle the FIFO stores the registered wr_data instead of dob.
- Writes in the capture cycle itself are not forwarded; the read was already committed.
- Not defined: the wr_* ports exist but are ignored. A read that collides with a write returns dob unmodified, with undefined content.

Test Plan:
- Preload mem[i]=0x1000+i. Command addr=4, len=3, rsp_ready=1 -> enb in cycles 1-4; rsp_data 0x1004..0x1007 in cycles 3-6; rsp_last only with 0x1007; cmd_ready=1 from cycle 7.
- Command addr=510, len=3 with SIZE=512 -> addrb sequence 510, 511, 0, 1; data 0x11FE, 0x11FF, 0x1000, 0x1001.
- Command addr=0, len=7; rsp_ready=0 for cycles 0-9, then 1 -> enb pulses exactly twice, then holds 0; rsp_data stays 0x1000 while stalled; all 8 words delivered in order with none lost or duplicated.
- rsp_ready toggling 1,0,1,0 over an 8-word burst -> exact in-order sequence; rsp_last asserted once.
- Assert reset_n=0 in the middle of a 16-word burst -> all outputs reach reset values immediately. After release, no rsp_valid until a command addr=2, len=0, which returns 0x1002 with rsp_last=1.
- With BRAM_READ_BYPASS_EN defined, wr_en=1, wr_addr=5, wr_data=0xDEADBEEF in the same cycle as the addrb=5 issue -> word 5 returned as 0xDEADBEEF. Without the macro, this check is skipped.
